// File: rtl/g3_table_arbiter.sv
// Single-port table arbiter: lookups and updates (write / ruleID modify) share one synchronous-read
// table port; updates win arbitration until a waiting lookup has been starved STARVE_LIMIT times.
module g3_table_arbiter #(
  parameter int unsigned DATA_W           = 171,
  parameter int unsigned ADDR_W           = 11,
  parameter int unsigned TABLE_ENTRY_SIZE = 1737,
  parameter int unsigned STARVE_LIMIT     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_ready,
  output logic              lk_rsp_valid,
  output logic [DATA_W-1:0] lk_rsp_data,
  output logic              lk_rsp_err,
  input  logic              up_valid,
  input  logic [1:0]        up_op,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [DATA_W-1:0] up_data,
  input  logic [10:0]       up_rid,
  output logic              up_ready,
  output logic              up_done,
  output logic              up_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int unsigned       CntW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0]   StarveMax = CntW'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] MaxAddr   = ADDR_W'(TABLE_ENTRY_SIZE);
  localparam int unsigned       RidLo     = 11;
  localparam int unsigned       RidW      = 11;
  localparam logic [1:0]        OpWrite   = 2'b01;
  localparam logic [1:0]        OpModify  = 2'b10;

  typedef enum logic [1:0] {StIdle, StRd, StCap, StWr} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_din_q, mem_din_d;
  logic                mem_we_q, mem_we_d;
  logic [RidW-1:0]     rid_q, rid_d;
  logic                is_lk_q, is_lk_d;
  logic                lk_rsp_valid_q, lk_rsp_valid_d;
  logic                lk_rsp_err_q, lk_rsp_err_d;
  logic [DATA_W-1:0]   lk_rsp_data_q, lk_rsp_data_d;
  logic                up_done_q, up_done_d;
  logic                up_err_q, up_err_d;

  logic idle, starved, lk_bad, up_bad;

  assign idle     = (state_q == StIdle) && !rst;
  assign starved  = (starve_q == StarveMax);
  assign lk_ready = idle && (!up_valid || starved);
  assign up_ready = idle && !(lk_valid && starved);
  assign lk_bad   = (lk_addr > MaxAddr);
  assign up_bad   = ((up_op != OpWrite) && (up_op != OpModify)) || (up_addr > MaxAddr);

  always_comb begin
    state_d        = state_q;
    starve_d       = starve_q;
    mem_addr_d     = mem_addr_q;
    mem_din_d      = mem_din_q;
    rid_d          = rid_q;
    is_lk_d        = is_lk_q;
    lk_rsp_valid_d = 1'b0;
    lk_rsp_err_d   = 1'b0;
    lk_rsp_data_d  = lk_rsp_data_q;
    up_done_d      = 1'b0;
    up_err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lk_ready && lk_valid) begin
          starve_d = '0;
          if (lk_bad) begin
            lk_rsp_valid_d = 1'b1;
            lk_rsp_err_d   = 1'b1;
            lk_rsp_data_d  = '0;
          end else begin
            state_d    = StRd;
            mem_addr_d = lk_addr;
            is_lk_d    = 1'b1;
          end
        end else if (up_ready && up_valid) begin
          // Only a lookup that is actually waiting accumulates starvation credit.
          if (!lk_valid) begin
            starve_d = '0;
          end else if (!starved) begin
            starve_d = starve_q + CntW'(1);
          end
          if (up_bad) begin
            up_done_d = 1'b1;
            up_err_d  = 1'b1;
          end else if (up_op == OpWrite) begin
            state_d    = StWr;
            mem_addr_d = up_addr;
            mem_din_d  = up_data;
          end else begin
            state_d    = StRd;
            mem_addr_d = up_addr;
            rid_d      = up_rid;
            is_lk_d    = 1'b0;
          end
        end
      end
      StRd: state_d = StCap;
      StCap: begin
        if (is_lk_q) begin
          lk_rsp_valid_d = 1'b1;
          lk_rsp_data_d  = mem_dout;
          state_d        = StIdle;
        end else begin
          mem_din_d                = mem_dout;
          mem_din_d[RidLo +: RidW] = rid_q;
          state_d                  = StWr;
        end
      end
      StWr: begin
        up_done_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign mem_we_d = (state_d == StWr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      starve_q       <= '0;
      mem_addr_q     <= '0;
      mem_din_q      <= '0;
      mem_we_q       <= 1'b0;
      rid_q          <= '0;
      is_lk_q        <= 1'b0;
      lk_rsp_valid_q <= 1'b0;
      lk_rsp_err_q   <= 1'b0;
      lk_rsp_data_q  <= '0;
      up_done_q      <= 1'b0;
      up_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
      mem_we_q       <= mem_we_d;
      rid_q          <= rid_d;
      is_lk_q        <= is_lk_d;
      lk_rsp_valid_q <= lk_rsp_valid_d;
      lk_rsp_err_q   <= lk_rsp_err_d;
      lk_rsp_data_q  <= lk_rsp_data_d;
      up_done_q      <= up_done_d;
      up_err_q       <= up_err_d;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_we       = mem_we_q;
  assign lk_rsp_valid = lk_rsp_valid_q;
  assign lk_rsp_err   = lk_rsp_err_q;
  assign lk_rsp_data  = lk_rsp_data_q;
  assign up_done      = up_done_q;
  assign up_err       = up_err_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_g3_table_arbiter.sv
// Bench for g3_table_arbiter: sync-read table model, shadow reference table, directed and random
// transactions checked cycle by cycle with immediate assertions.
module tb_g3_table_arbiter;

  localparam int unsigned DATA_W = 171;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned TSIZE  = 1737;

  logic              clk = 1'b0;
  logic              rst;
  logic              lk_valid, lk_ready, lk_rsp_valid, lk_rsp_err;
  logic [ADDR_W-1:0] lk_addr;
  logic [DATA_W-1:0] lk_rsp_data;
  logic              up_valid, up_ready, up_done, up_err;
  logic [1:0]        up_op;
  logic [ADDR_W-1:0] up_addr;
  logic [DATA_W-1:0] up_data;
  logic [10:0]       up_rid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_din, mem_dout;
  logic              busy;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;

  logic [DATA_W-1:0] tmem    [0:TSIZE];
  logic [DATA_W-1:0] ref_tbl [0:TSIZE];

  int n_checks = 0;
  int n_fail   = 0;

  g3_table_arbiter dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data), .lk_rsp_err(lk_rsp_err),
    .up_valid(up_valid), .up_op(up_op), .up_addr(up_addr), .up_data(up_data),
    .up_rid(up_rid), .up_ready(up_ready), .up_done(up_done), .up_err(up_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Table with one cycle of read latency; preload port only used while the DUT is in reset.
  always @(posedge clk) begin
    if (mem_we) tmem[mem_addr] <= mem_din;
    else if (pre_we) tmem[pre_addr] <= pre_data;
    mem_dout <= tmem[mem_addr];
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] with_rid(input logic [DATA_W-1:0] d,
                                                 input logic [10:0] rid);
    logic [DATA_W-1:0] field, newf;
    field = DATA_W'(11'h7FF) << 11;
    newf  = DATA_W'(rid) << 11;
    return (d & ~field) | newf;
  endfunction

  task automatic scramble();
    lk_addr = ADDR_W'($urandom());
    up_addr = ADDR_W'($urandom());
    up_op   = 2'($urandom());
    up_rid  = 11'($urandom());
    up_data = rand_data();
  endtask

  function automatic logic [ADDR_W-1:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return ADDR_W'(TSIZE);
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_lookup(input logic [ADDR_W-1:0] a);
    logic bad;
    bad = (a > ADDR_W'(TSIZE));
    lk_valid = 1'b1; lk_addr = a; up_valid = 1'b0;
    #1 chk("lk_ready", lk_ready, 1'b1);
    @(negedge clk);
    lk_valid = 1'b0;
    scramble();
    if (bad) begin
      chk("lk_err_valid", lk_rsp_valid, 1'b1);
      chk("lk_err_flag", lk_rsp_err, 1'b1);
      chk("lk_err_data", lk_rsp_data, '0);
      chk("lk_err_busy", busy, 1'b0);
      chk("lk_err_we", mem_we, 1'b0);
      @(negedge clk);
      chk("lk_err_pulse", lk_rsp_valid, 1'b0);
    end else begin
      chk("rd_busy", busy, 1'b1);
      chk("rd_addr", mem_addr, a);
      chk("rd_we", mem_we, 1'b0);
      @(negedge clk);
      chk("cap_rsp", lk_rsp_valid, 1'b0);
      chk("cap_we", mem_we, 1'b0);
      @(negedge clk);
      chk("rsp_valid", lk_rsp_valid, 1'b1);
      chk("rsp_err", lk_rsp_err, 1'b0);
      chk("rsp_data", lk_rsp_data, ref_tbl[a]);
      @(negedge clk);
      chk("rsp_pulse", lk_rsp_valid, 1'b0);
      chk("rsp_hold", lk_rsp_data, ref_tbl[a]);
    end
  endtask

  task automatic do_update(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [10:0] rid);
    logic              bad;
    logic [DATA_W-1:0] exp;
    bad = ((op != 2'b01) && (op != 2'b10)) || (a > ADDR_W'(TSIZE));
    up_valid = 1'b1; up_op = op; up_addr = a; up_data = d; up_rid = rid; lk_valid = 1'b0;
    #1 chk("up_ready", up_ready, 1'b1);
    @(negedge clk);
    up_valid = 1'b0;
    scramble();
    if (bad) begin
      chk("up_err_done", up_done, 1'b1);
      chk("up_err_flag", up_err, 1'b1);
      chk("up_err_busy", busy, 1'b0);
      chk("up_err_we", mem_we, 1'b0);
      @(negedge clk);
      chk("up_err_pulse", up_done, 1'b0);
      chk("up_err_we2", mem_we, 1'b0);
    end else if (op == 2'b01) begin
      chk("wr_we", mem_we, 1'b1);
      chk("wr_addr", mem_addr, a);
      chk("wr_din", mem_din, d);
      @(negedge clk);
      chk("wr_we_off", mem_we, 1'b0);
      chk("wr_done", up_done, 1'b1);
      chk("wr_noerr", up_err, 1'b0);
      ref_tbl[a] = d;
    end else begin
      exp = with_rid(ref_tbl[a], rid);
      chk("md_rd_addr", mem_addr, a);
      chk("md_rd_we", mem_we, 1'b0);
      @(negedge clk);
      chk("md_cap_we", mem_we, 1'b0);
      chk("md_cap_done", up_done, 1'b0);
      @(negedge clk);
      chk("md_wr_we", mem_we, 1'b1);
      chk("md_wr_addr", mem_addr, a);
      chk("md_wr_din", mem_din, exp);
      chk("md_wr_done", up_done, 1'b0);
      @(negedge clk);
      chk("md_done", up_done, 1'b1);
      chk("md_noerr", up_err, 1'b0);
      chk("md_we_off", mem_we, 1'b0);
      ref_tbl[a] = exp;
    end
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [10:0]       r;
    int                grants, rsp_cnt, kind;

    rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    lk_valid = 1'b1; up_valid = 1'b1;
    scramble();

    // Preload table and shadow copy while held in reset.
    for (int i = 0; i <= int'(TSIZE); i++) begin
      @(negedge clk);
      d = rand_data();
      pre_we = 1'b1; pre_addr = ADDR_W'(i); pre_data = d;
      ref_tbl[i] = d;
    end
    @(negedge clk);
    pre_we = 1'b0;
    #1;
    chk("rst_lk_ready", lk_ready, 1'b0);
    chk("rst_up_ready", up_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_din", mem_din, '0);
    chk("rst_rsp", {lk_rsp_valid, lk_rsp_err, up_done, up_err}, 4'b0);
    chk("rst_rsp_data", lk_rsp_data, '0);
    lk_valid = 1'b0; up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed basics.
    do_lookup(11'd5);
    d = rand_data();
    do_update(2'b01, 11'd10, d, 11'd0);
    do_lookup(11'd10);
    do_update(2'b10, 11'd3, rand_data(), 11'h7FF);
    do_lookup(11'd3);
    do_lookup(11'd1738);
    do_update(2'b11, 11'd7, rand_data(), 11'd1);
    do_update(2'b00, 11'd7, rand_data(), 11'd1);
    do_update(2'b01, 11'd2047, rand_data(), 11'd1);
    do_update(2'b10, ADDR_W'(TSIZE), rand_data(), 11'h155);
    do_lookup(ADDR_W'(TSIZE));

    // Both requesters held: expect update x4, lookup x1, repeating.
    d = rand_data();
    lk_valid = 1'b1; lk_addr = 11'd21;
    up_valid = 1'b1; up_op = 2'b01; up_addr = 11'd20; up_data = d;
    grants = 0; rsp_cnt = 0;
    for (int cyc = 0; cyc < 300 && grants < 15; cyc++) begin
      #1;
      chk("arb_one_grant", lk_ready & up_ready, 1'b0);
      if (lk_ready || up_ready) begin
        chk("arb_order", lk_ready, (grants % 5) == 4);
        grants++;
        if (up_ready) ref_tbl[20] = d;
      end
      if (lk_rsp_valid) begin
        chk("arb_rsp_data", lk_rsp_data, ref_tbl[21]);
        rsp_cnt++;
      end
      @(negedge clk);
    end
    lk_valid = 1'b0; up_valid = 1'b0;
    chk("arb_grants", grants, 15);
    for (int i = 0; i < 5; i++) begin
      #1;
      if (lk_rsp_valid) begin
        chk("arb_rsp_data", lk_rsp_data, ref_tbl[21]);
        rsp_cnt++;
      end
      @(negedge clk);
    end
    chk("arb_rsp_count", rsp_cnt, 3);
    do_lookup(11'd20);

    // Reset while a modify sits in CAP.
    r = 11'($urandom());
    up_valid = 1'b1; up_op = 2'b10; up_addr = 11'd3; up_rid = r; lk_valid = 1'b0;
    #1 chk("mrst_ready", up_ready, 1'b1);
    @(negedge clk);
    up_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_we", mem_we, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_done", up_done, 1'b0);
    chk("mrst_addr", mem_addr, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_we2", mem_we, 1'b0);
    chk("mrst_done2", up_done, 1'b0);
    do_lookup(11'd3);

    // Random single transactions against the shadow table.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0: do_lookup(pick_addr());
        1: do_lookup(ADDR_W'($urandom_range(TSIZE + 1, 2047)));
        2: do_update(2'b01, pick_addr(), rand_data(), 11'($urandom()));
        3: do_update(2'b10, pick_addr(), rand_data(), 11'($urandom()));
        4: do_update(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, pick_addr(), rand_data(),
                     11'($urandom()));
        default: do_update(2'($urandom_range(1, 2)), ADDR_W'($urandom_range(TSIZE + 1, 2047)),
                           rand_data(), 11'($urandom()));
      endcase
    end
    for (int a = 0; a < 16; a++) do_lookup(ADDR_W'(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/g3_table_arbiter.md
G3_TABLE_ARBITER -- requirements
Module: g3_table_arbiter

Interface
REQ-001 SHALL have parameters: DATA_W, 171, table entry width; ADDR_W, 11, table address width; TABLE_ENTRY_SIZE, 1737, highest valid address; STARVE_LIMIT, 4, consecutive update grants allowed while a lookup waits.
REQ-002 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock
- rst, in, 1, sync active-high reset
- lk_valid, in, 1, lookup request
- lk_addr, in, ADDR_W, lookup address
- lk_ready, out, 1, lookup accepted
- lk_rsp_valid, out, 1, one-cycle response strobe
- lk_rsp_data, out, DATA_W, entry read
- lk_rsp_err, out, 1, address out of range
- up_valid, in, 1, update request
- up_op, in, 2, 01 = write entry, 10 = modify ruleID
- up_addr, in, ADDR_W, update address
- up_data, in, DATA_W, entry for write
- up_rid, in, 11, new ruleID for modify
- up_ready, out, 1, update accepted
- up_done, out, 1, one-cycle completion strobe
- up_err, out, 1, qualifies up_done: bad op or address
- mem_addr, out, ADDR_W, table address
- mem_we, out, 1, table write enable
- mem_din, out, DATA_W, table write data
- mem_dout, in, DATA_W, table read data, 1-cycle latency
- busy, out, 1, state != IDLE

Function
REQ-004 SHALL implement FSM states IDLE, RD, CAP, WR; handshake = valid & ready at a rising edge.
REQ-005 lk_ready/up_ready SHALL be combinational, high only in IDLE with rst low; never both high in the same cycle when both valids are high.
REQ-006 Arbitration in IDLE: update wins unless lk_valid=1 and starve_cnt == STARVE_LIMIT, in which case the lookup wins.
REQ-007 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each update accept while lk_valid=1; SHALL clear on a lookup accept or on an update accept with lk_valid=0.
REQ-008 Lookup path: IDLE→RD (mem_addr=lk_addr, mem_we=0)→CAP→IDLE; in CAP, lk_rsp_data SHALL be registered from mem_dout; lk_rsp_valid=1 for one cycle, 3 cycles after the accept edge.
REQ-009 Write op: IDLE→WR (mem_addr=up_addr, mem_din=up_data, mem_we=1 for exactly one cycle)→IDLE; up_done SHALL pulse the cycle after WR.
REQ-010 Modify op: IDLE→RD→CAP→WR→IDLE; WR data SHALL equal captured mem_dout with bits [21:11] replaced by up_rid and all other bits unchanged; up_done SHALL pulse the cycle after WR.
REQ-011 The request address, op, data and rid SHALL be registered at accept; later input changes SHALL NOT affect the operation in flight.
REQ-012 An address > TABLE_ENTRY_SIZE SHALL be accepted with no memory access (mem_we stays 0); FSM stays in IDLE; the err strobe (lk_rsp_valid+lk_rsp_err with lk_rsp_data=0, or up_done+up_err) SHALL pulse the cycle after the accept.
REQ-013 up_op 00 or 11 SHALL be handled as REQ-012 with up_err=1.
REQ-014 mem_we SHALL be 1 only in WR; mem_addr/mem_din SHALL be registered outputs; lk_rsp_data SHALL hold its value until the next response.
REQ-015 Simultaneous lk_valid and up_valid SHALL produce exactly one grant per IDLE cycle; the losing request SHALL stay pending and SHALL NOT be dropped.

Reset
REQ-016 While rst=1: state=IDLE, starve_cnt=0, and every output register (lk_rsp_valid, lk_rsp_data, lk_rsp_err, up_done, up_err, mem_addr, mem_we, mem_din) =0, so busy=0.
REQ-017 Reset mid-operation SHALL abandon the operation with no up_done/lk_rsp_valid pulse; mem_we SHALL be 0 in the cycle after the reset edge.

Verification
REQ-018 Lookup lk_addr=5, table[5]=X → RD shows mem_addr=5, mem_we=0; lk_rsp_valid=1, lk_rsp_data=X, 3 cycles after accept.
REQ-019 Write up_op=01, addr=10, data=D → one cycle of mem_we=1, mem_addr=10, mem_din=D; up_done=1, up_err=0 the next cycle; a later lookup of 10 returns D.
REQ-020 Modify up_op=10, addr=3, rid=0x7FF, table[3]=E → written value equals E with [21:11]=0x7FF; up_done 4 cycles after accept.
REQ-021 lk_valid and up_valid held high continuously → grant order: 4 updates, 1 lookup, repeating; no request lost.
REQ-022 lk_addr=1738, then up_op=11 → each is accepted with no mem_we; err strobe the cycle after accept; FSM stays in IDLE.
REQ-023 rst asserted during CAP of a modify → no mem_we, no up_done; busy=0 after reset; the next request is served normally.
